// File: rtl/fp_pkg.sv
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared FP32 constants and encodings for the normaliser slice:
//            field widths, bias, maximum exponent code, operand class and
//            rounding-mode encodings, canonical quiet NaN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int FP_W      = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS   = 127;
  localparam int EXP_MAX   = 255;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } fp_class_e;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } round_mode_e;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// ============================================================================
// Module   : fp_lzc
// Purpose  : Parameterised leading-zero counter. An all-zero input returns
//            WIDTH.
// Ports    : din [WIDTH-1:0] in  - value to scan
//            cnt [CNT_W-1:0] out - number of leading zeros (0..WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_lzc #(
  parameter int WIDTH = 48,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Scan upward so the highest set bit is the last assignment to win.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_normalize_pipe.sv
// ============================================================================
// Module   : fp_normalize_pipe
// Purpose  : Two-stage normaliser ahead of the FP32 rounder. Stage 1 counts
//            leading zeros; stage 2 shifts, rebiases, handles subnormals,
//            overflow and special classes, and produces guard/round/sticky.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready, in_sign, in_exp[EXP_W], in_mant[MANT_W],
//            in_class[2], in_round_mode[2]
//            out_valid/out_ready, out_data[32], out_guard, out_round,
//            out_sticky, out_round_mode[2], out_ovf, out_unf
// Macro    : FP_NORM_FTZ_EN - when defined, subnormal results flush to a
//            signed zero with out_unf set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_normalize_pipe
  import fp_pkg::*;
#(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [1:0]        in_class,
  input  logic [1:0]        in_round_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_guard,
  output logic              out_round,
  output logic              out_sticky,
  output logic [1:0]        out_round_mode,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam int LZ_W = $clog2(MANT_W + 1);
  localparam int EN_W = EXP_W + 2;
  localparam int XW   = 2 * MANT_W;

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s1_en, s2_en;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // ---------------- stage 1 ----------------
  logic [LZ_W-1:0]   in_lz;
  logic [1:0]        in_class_eff;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [MANT_W-1:0] s1_mant;
  logic [1:0]        s1_class;
  logic [1:0]        s1_rm;
  logic [LZ_W-1:0]   s1_lz;

  fp_lzc #(.WIDTH(MANT_W), .CNT_W(LZ_W)) u_lzc (
    .din (in_mant),
    .cnt (in_lz)
  );

  // A "normal" operand with no magnitude is really a zero.
  assign in_class_eff = (in_class == CLS_NORMAL && in_mant == '0) ? CLS_ZERO : in_class;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_class <= '0;
      s1_rm    <= '0;
      s1_lz    <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_exp   <= in_exp;
        s1_mant  <= in_mant;
        s1_class <= in_class_eff;
        s1_rm    <= in_round_mode;
        s1_lz    <= in_lz;
      end
    end
  end

  // ---------------- stage 2 arithmetic ----------------
  logic [EN_W-1:0]   exp_ext, lz_ext, e_n, sh_full, sh;
  logic [MANT_W-1:0] shifted;
  logic [XW-1:0]     ext;
  logic              is_sub, is_ovf;
  logic [22:0]       frac;
  logic              g_bit, r_bit, s_bit;
  logic              unused_hidden;

  assign exp_ext = {{2{s1_exp[EXP_W-1]}}, s1_exp};
  assign lz_ext  = {{(EN_W-LZ_W){1'b0}}, s1_lz};
  assign e_n     = exp_ext + EN_W'(1) - lz_ext;
  assign shifted = s1_mant << s1_lz;

  // e_n is two's complement: negative or zero means subnormal.
  assign is_sub  = e_n[EN_W-1] || (e_n == '0);
  assign is_ovf  = !is_sub && (e_n >= EN_W'(EXP_MAX));

  // Denormalising shift; beyond MANT_W every bit already lands in sticky.
  assign sh_full = EN_W'(1) - e_n;
  assign sh      = !is_sub ? '0 : ((sh_full > EN_W'(MANT_W)) ? EN_W'(MANT_W) : sh_full);

  // Lower half catches shifted-out bits so sticky sees them.
  assign ext     = {shifted, {MANT_W{1'b0}}} >> sh;
  assign frac    = ext[XW-2 -: 23];
  assign g_bit   = ext[XW-25];
  assign r_bit   = ext[XW-26];
  assign s_bit   = |ext[XW-27:0];
  // Hidden bit is implied by the exponent field, never stored.
  assign unused_hidden = ext[XW-1];

  logic [31:0] nxt_data;
  logic        nxt_g, nxt_r, nxt_s, nxt_ovf, nxt_unf;

  always_comb begin
    nxt_data = {s1_sign, e_n[FP_EXP_W-1:0], frac};
    nxt_g    = g_bit;
    nxt_r    = r_bit;
    nxt_s    = s_bit;
    nxt_ovf  = 1'b0;
    nxt_unf  = 1'b0;
    case (s1_class)
      CLS_ZERO: begin
        nxt_data = {s1_sign, 31'h0};
        {nxt_g, nxt_r, nxt_s} = 3'b000;
      end
      CLS_INF: begin
        nxt_data = {s1_sign, 8'hFF, 23'h0};
        {nxt_g, nxt_r, nxt_s} = 3'b000;
      end
      CLS_NAN: begin
        nxt_data = QNAN;
        {nxt_g, nxt_r, nxt_s} = 3'b000;
      end
      default: begin
        if (is_ovf) begin
          nxt_data = {s1_sign, 8'hFF, 23'h0};
          {nxt_g, nxt_r, nxt_s} = 3'b000;
          nxt_ovf  = 1'b1;
        end else if (is_sub) begin
`ifdef FP_NORM_FTZ_EN
          nxt_data = {s1_sign, 31'h0};
          {nxt_g, nxt_r, nxt_s} = 3'b000;
          nxt_unf  = 1'b1;
`else
          nxt_data = {s1_sign, 8'h00, frac};
          nxt_unf  = (|frac) | g_bit | r_bit | s_bit;
`endif
        end
      end
    endcase
  end

  // ---------------- stage 2 register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_guard      <= 1'b0;
      out_round      <= 1'b0;
      out_sticky     <= 1'b0;
      out_round_mode <= '0;
      out_ovf        <= 1'b0;
      out_unf        <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data       <= nxt_data;
        out_guard      <= nxt_g;
        out_round      <= nxt_r;
        out_sticky     <= nxt_s;
        out_round_mode <= s1_rm;
        out_ovf        <= nxt_ovf;
        out_unf        <= nxt_unf;
      end
    end
  end

endmodule

`default_nettype wire
